leap_buffer: RTL and testbench
==============================

LEAP_BUFFER -- requirements
Module: leap_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of leapfrogged-instruction entries held (legal 1..4).
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 leap  in  1  hazard unit grant: EX instruction may retire past the MA-stage miss.
REQ-005 miss  in  1  MA data-memory miss outstanding.
REQ-006 ex_valid, ex_regwrite  in  1 each  EX instruction valid / writes rd.
REQ-007 ex_rd  in  5; ex_result, ex_pc  in  32 each  EX destination, ALU result, PC.
REQ-008 ma_done  in  1  MA miss response returned this cycle.
REQ-009 ma_rd  in  5; ma_data  in  32; ma_regwrite  in  1  MA load/store writeback fields.
REQ-010 fwd_rs1, fwd_rs2  in  5 each  EX-stage source addresses for forwarding lookup.
REQ-011 wb_valid, wb_regwrite  out  1 each; wb_rd  out  5; wb_data, wb_pc  out  32 each  writeback port.
REQ-012 fwd1_hit, fwd2_hit  out  1 each; fwd1_data, fwd2_data  out  32 each  buffered forward values.
REQ-013 stall  out  1  freeze EX and upstream stages.
REQ-014 count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-015 States IDLE, HOLD, DRAIN; FIFO of DEPTH entries {rd, data, pc, regwrite}, head = oldest.
REQ-016 Capture = leap & ex_valid & miss & count<DEPTH & state!=DRAIN; entry written at tail on that edge, count+1.
REQ-017 IDLE: capture -> HOLD; else stay; wb_valid=0 from buffer.
REQ-018 HOLD: captures continue; stall=1 combinationally when count==DEPTH.
REQ-019 HOLD with ma_done: same cycle wb_valid=1 with MA fields (wb_pc=0); next state DRAIN if post-edge count>0, else IDLE.
REQ-020 Capture coincident with ma_done is accepted into tail before DRAIN.
REQ-021 DRAIN: one head entry per cycle on wb port, count-1 per edge; stall=1 every DRAIN cycle; pop leaving count==0 -> IDLE.
REQ-022 Writeback order strictly: MA result, then buffered entries in capture order.
REQ-023 Entry with rd==0 is captured and drained, but wb_regwrite=0.
REQ-024 leap while count==DEPTH or in DRAIN: ignored, no state change.
REQ-025 ma_done in IDLE or DRAIN: ignored.
REQ-026 fwdN_hit=1 when any valid entry has regwrite=1, rd==fwd_rsN, rd!=0; data from youngest match; combinational.
REQ-027 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor goes below 0.

Reset
REQ-028 rst=0 at an edge: state IDLE, count 0, pointers 0, entries invalid, regardless of state.
REQ-029 During/after reset: wb_valid=0, stall=0, fwd hits 0, count=0.

Verification
REQ-030 Single leap: miss=1, leap with rd=5, result 0x11 (pc 0x100); ma_done rd=3 data 0xAA next cycle -> wb rd3/0xAA, then rd5/0x11 pc 0x100, then IDLE, stall=1 only in drain cycle.
REQ-031 Full: DEPTH=2, three leap cycles (rd 1,2,4) -> rd4 dropped, stall=1 after second capture, count=2.
REQ-032 Forwarding: buffered rd=7 data 0x5 then rd=7 data 0x9; fwd_rs1=7 -> fwd1_hit=1, data 0x9; fwd_rs2=0 -> hit 0.
REQ-033 Simultaneous: leap rd=6 same cycle as ma_done -> wb MA result, next cycle wb rd6, then IDLE.
REQ-034 rd=0 leap, data 0xFF -> drained with wb_valid=1, wb_regwrite=0.
REQ-035 Reset mid-DRAIN with count=2 -> next cycle count=0, IDLE, wb_valid=0, stall=0.

Source files
------------

// File: rtl/leap_buffer.sv
// Leapfrog writeback buffer: holds EX results that retire past an outstanding
// MA-stage miss, then drains them in capture order after the miss returns.
module leap_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       leap,
  input  logic                       miss,
  input  logic                       ex_valid,
  input  logic                       ex_regwrite,
  input  logic [4:0]                 ex_rd,
  input  logic [31:0]                ex_result,
  input  logic [31:0]                ex_pc,
  input  logic                       ma_done,
  input  logic [4:0]                 ma_rd,
  input  logic [31:0]                ma_data,
  input  logic                       ma_regwrite,
  input  logic [4:0]                 fwd_rs1,
  input  logic [4:0]                 fwd_rs2,
  output logic                       wb_valid,
  output logic                       wb_regwrite,
  output logic [4:0]                 wb_rd,
  output logic [31:0]                wb_data,
  output logic [31:0]                wb_pc,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [31:0]                fwd1_data,
  output logic [31:0]                fwd2_data,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic          r_rw   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_capture;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : PW'(p + 1'b1);
  endfunction

  assign w_capture = leap & ex_valid & miss & (r_count != FULL) & (r_state != S_DRAIN);
  assign w_pop     = (r_state == S_DRAIN) & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_capture, w_pop})
      2'b10:   w_count_nxt = CW'(r_count + 1'b1);
      2'b01:   w_count_nxt = CW'(r_count - 1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_capture) begin
        r_rd[r_tail]   <= ex_rd;
        r_data[r_tail] <= ex_result;
        r_pc[r_tail]   <= ex_pc;
        r_rw[r_tail]   <= ex_regwrite;
        r_tail         <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // A capture on the ma_done edge is already counted in w_count_nxt.
        if (ma_done) w_state_nxt = (w_count_nxt != '0) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (w_count_nxt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_valid    = 1'b0;
    wb_regwrite = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    wb_pc       = '0;
    stall       = 1'b0;
    count       = '0;
    if (rst) begin
      count = r_count;
      if (r_state == S_HOLD) begin
        stall = (r_count == FULL);
        if (ma_done) begin
          wb_valid    = 1'b1;
          wb_regwrite = ma_regwrite;
          wb_rd       = ma_rd;
          wb_data     = ma_data;
        end
      end else if (r_state == S_DRAIN) begin
        stall       = 1'b1;
        wb_valid    = 1'b1;
        wb_regwrite = r_rw[r_head] & (r_rd[r_head] != 5'd0);
        wb_rd       = r_rd[r_head];
        wb_data     = r_data[r_head];
        wb_pc       = r_pc[r_head];
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    int unsigned k;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    k         = 0;
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        k = int'(r_head) + i;
        if (k >= DEPTH) k = k - DEPTH;
        if ((i < int'(r_count)) && r_rw[k] && (r_rd[k] != 5'd0)) begin
          if (r_rd[k] == fwd_rs1) begin
            fwd1_hit  = 1'b1;
            fwd1_data = r_data[k];
          end
          if (r_rd[k] == fwd_rs2) begin
            fwd2_hit  = 1'b1;
            fwd2_data = r_data[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_leap_buffer.sv
// Self-checking bench for leap_buffer: directed scenarios then random traffic,
// all checked against a queue-based model of the buffer behaviour.
module tb_leap_buffer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, leap, miss, ex_valid, ex_regwrite, ma_done, ma_regwrite;
  logic [4:0]    ex_rd, ma_rd, fwd_rs1, fwd_rs2, wb_rd;
  logic [31:0]   ex_result, ex_pc, ma_data, wb_data, wb_pc, fwd1_data, fwd2_data;
  logic          wb_valid, wb_regwrite, fwd1_hit, fwd2_hit, stall;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  leap_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .leap(leap), .miss(miss),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_pc(ex_pc),
    .ma_done(ma_done), .ma_rd(ma_rd), .ma_data(ma_data), .ma_regwrite(ma_regwrite),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .stall(stall), .count(count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        rw;
  } ent_t;

  ent_t q[$];
  int   mode = 0;  // 0: no miss held, 1: miss held, 2: draining
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic        ev, erw, est, h1, h2;
    logic [4:0]  erd;
    logic [31:0] ed, ep, d1, d2, ec;
    ev = 0; erw = 0; est = 0; h1 = 0; h2 = 0;
    erd = '0; ed = '0; ep = '0; d1 = '0; d2 = '0; ec = '0;
    if (rst) begin
      ec = q.size();
      if (mode == 1 && ma_done) begin
        ev = 1; erd = ma_rd; ed = ma_data; ep = 0; erw = ma_regwrite;
      end else if (mode == 2) begin
        ev = 1; erd = q[0].rd; ed = q[0].data; ep = q[0].pc;
        erw = q[0].rw && (q[0].rd != 0);
      end
      est = (mode == 1 && q.size() == DEPTH) || mode == 2;
      foreach (q[i]) begin
        if (q[i].rw && q[i].rd != 0 && q[i].rd == fwd_rs1) begin h1 = 1; d1 = q[i].data; end
        if (q[i].rw && q[i].rd != 0 && q[i].rd == fwd_rs2) begin h2 = 1; d2 = q[i].data; end
      end
    end
    chk("wb_valid", wb_valid, ev);
    if (ev) begin
      chk("wb_rd", wb_rd, erd);
      chk("wb_data", wb_data, ed);
      chk("wb_pc", wb_pc, ep);
      chk("wb_regwrite", wb_regwrite, erw);
    end
    chk("stall", stall, est);
    chk("count", count, ec);
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd2_hit", fwd2_hit, h2);
    if (h1) chk("fwd1_data", fwd1_data, d1);
    if (h2) chk("fwd2_data", fwd2_data, d2);
  endtask

  task automatic model_update();
    logic cap;
    ent_t e;
    int   was;
    if (!rst) begin
      q.delete();
      mode = 0;
    end else begin
      cap = leap && ex_valid && miss && (q.size() < DEPTH) && mode != 2;
      e.rd = ex_rd; e.data = ex_result; e.pc = ex_pc; e.rw = ex_regwrite;
      was = mode;
      if (mode == 2) void'(q.pop_front());
      if (cap) q.push_back(e);
      case (was)
        0: mode = cap ? 1 : 0;
        1: mode = ma_done ? ((q.size() > 0) ? 2 : 0) : 1;
        default: mode = (q.size() == 0) ? 0 : 2;
      endcase
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1; leap = 0; miss = 0; ex_valid = 0; ex_regwrite = 0;
    ex_rd = '0; ex_result = '0; ex_pc = '0;
    ma_done = 0; ma_rd = '0; ma_data = '0; ma_regwrite = 0;
    fwd_rs1 = '0; fwd_rs2 = '0;
  endtask

  task automatic lp(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
    idle();
    leap = 1; miss = 1; ex_valid = 1; ex_regwrite = 1;
    ex_rd = rd; ex_result = d; ex_pc = pc;
  endtask

  task automatic done(input logic [4:0] rd, input logic [31:0] d);
    ma_done = 1; ma_rd = rd; ma_data = d; ma_regwrite = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    settle(); tick();
    settle(); chk("rst_count", count, 0); chk("rst_stall", stall, 0); tick();

    // Single leap past a miss
    idle(); lp(5'd5, 32'h11, 32'h100);
    settle(); chk("s_stall0", stall, 0); tick();
    idle(); miss = 1; done(5'd3, 32'hAA);
    settle(); chk("s_ma_rd", wb_rd, 3); chk("s_ma_data", wb_data, 32'hAA); chk("s_ma_stall", stall, 0); tick();
    idle();
    settle(); chk("s_dr_rd", wb_rd, 5); chk("s_dr_pc", wb_pc, 32'h100); chk("s_dr_stall", stall, 1); tick();
    settle(); chk("s_idle_wb", wb_valid, 0); chk("s_idle_stall", stall, 0); tick();

    // Fill to DEPTH, third leap dropped
    lp(5'd1, 32'h1, 32'h200); settle(); tick();
    lp(5'd2, 32'h2, 32'h204); settle(); chk("f_stall1", stall, 0); tick();
    lp(5'd4, 32'h4, 32'h208); settle(); chk("f_stall2", stall, 1); chk("f_count", count, 2); tick();
    idle(); miss = 1; done(5'd9, 32'h99); settle(); tick();
    idle();
    settle(); chk("f_dr1", wb_rd, 1); tick();
    settle(); chk("f_dr2", wb_rd, 2); tick();
    settle(); chk("f_end", wb_valid, 0); tick();

    // Forwarding picks the youngest match
    lp(5'd7, 32'h5, 32'h300); settle(); tick();
    lp(5'd7, 32'h9, 32'h304); settle(); tick();
    idle(); miss = 1; fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
    settle(); chk("fw_hit1", fwd1_hit, 1); chk("fw_data1", fwd1_data, 32'h9); chk("fw_hit2", fwd2_hit, 0); tick();
    idle(); miss = 1; done(5'd10, 32'h10); settle(); tick();
    idle(); settle(); tick(); settle(); tick(); settle(); tick();

    // Capture coincident with ma_done lands before the drain
    lp(5'd8, 32'h8, 32'h400); settle(); tick();
    lp(5'd6, 32'h6, 32'h404); done(5'd11, 32'hBB);
    settle(); chk("c_ma_rd", wb_rd, 11); tick();
    idle();
    settle(); chk("c_dr8", wb_rd, 8); tick();
    settle(); chk("c_dr6", wb_rd, 6); tick();
    settle(); chk("c_end", wb_valid, 0); tick();

    // rd==0 entry drains without register write
    lp(5'd0, 32'hFF, 32'h500); settle(); tick();
    idle(); miss = 1; done(5'd12, 32'h12); settle(); tick();
    idle();
    settle(); chk("z_valid", wb_valid, 1); chk("z_rw", wb_regwrite, 0); chk("z_data", wb_data, 32'hFF); tick();
    settle(); tick();

    // Reset in the middle of a drain
    lp(5'd1, 32'h21, 32'h600); settle(); tick();
    lp(5'd2, 32'h22, 32'h604); settle(); tick();
    idle(); miss = 1; done(5'd13, 32'h13); settle(); tick();
    idle(); settle(); chk("r_drain_cnt", count, 2); rst = 0; settle(); tick();
    idle();
    settle(); chk("r_cnt", count, 0); chk("r_wb", wb_valid, 0); chk("r_stall", stall, 0); tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(63) != 0);
      leap        = 1'($urandom_range(1));
      miss        = ($urandom_range(3) != 0);
      ex_valid    = ($urandom_range(3) != 0);
      ex_regwrite = ($urandom_range(3) != 0);
      ex_rd       = 5'($urandom_range(7));
      ex_result   = $urandom;
      ex_pc       = $urandom;
      ma_done     = ($urandom_range(3) == 0);
      ma_rd       = 5'($urandom_range(31));
      ma_data     = $urandom;
      ma_regwrite = 1'($urandom_range(1));
      fwd_rs1     = 5'($urandom_range(7));
      fwd_rs2     = 5'($urandom_range(7));
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
